// File: rtl/prog_fifo.sv
// ---------------------------------------------------------------------------
// prog_fifo -- synchronous FIFO with programmable almost-full/almost-empty
// flags, zero-latency head read and an empty-FIFO bypass path.
//
// Storage is a DEPTH-entry register array addressed by rd/wr indexes that
// wrap by compare, so DEPTH need not be a power of two. Occupancy lives in a
// dedicated count register; empty/full are decoded from it alone.
//
// Optional feature: define PROG_FIFO_ERR_EN to build the sticky
// overflow/underflow flags. Without it both outputs are tied low.
//
// Parameters
//   WIDTH      data width in bits
//   DEPTH      number of entries (>= 2)
//   CW         derived, $clog2(DEPTH+1): width of count and thresholds
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   push       write request
//   pop        read request
//   flush      synchronous clear, overrides push/pop
//   wdata      write data
//   af_thresh  almost-full threshold, 0 disables al_full
//   ae_thresh  almost-empty threshold
//   rdata      head data (combinational), wdata while bypassing
//   full       count == DEPTH
//   empty      count == 0
//   al_full    (af_thresh != 0) & (count >= af_thresh)
//   al_empty   count <= ae_thresh
//   count      current occupancy
//   ack        push accepted this cycle
//   valid      rdata is a legal pop this cycle
//   overflow   sticky: push while full without pop
//   underflow  sticky: pop while empty without push
// ---------------------------------------------------------------------------
module prog_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 24,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    input  logic [CW-1:0]    af_thresh,
    input  logic [CW-1:0]    ae_thresh,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             al_full,
    output logic             al_empty,
    output logic [CW-1:0]    count,
    output logic             ack,
    output logic             valid,
    output logic             overflow,
    output logic             underflow
);

    localparam int              IW        = $clog2(DEPTH);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [CW-1:0]   DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [CW-1:0] count_q,  count_d;

    logic bypass;
    logic wen;
    logic ren;

    // Index advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IW'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Status decode
    // -----------------------------------------------------------------------
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_CNT);
    assign count    = count_q;
    assign al_full  = (af_thresh != '0) && (count_q >= af_thresh);
    assign al_empty = (count_q <= ae_thresh);

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    // An empty FIFO with simultaneous push and pop hands wdata straight
    // through; nothing is stored and no state moves.
    assign bypass = empty & push & pop & ~flush;

    // When full, a push is still accepted if a pop frees the head slot in
    // the same cycle.
    assign wen    = push & ~flush & ~bypass & (~full | pop);
    assign ren    = pop & ~empty & ~flush;

    assign ack    = wen | bypass;
    assign valid  = ren | bypass;
    assign rdata  = bypass ? wdata : mem_q[rd_idx_q];

    // -----------------------------------------------------------------------
    // Next-state for indexes and occupancy
    // -----------------------------------------------------------------------
    always_comb begin
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        count_d  = count_q;
        if (flush) begin
            rd_idx_d = '0;
            wr_idx_d = '0;
            count_d  = '0;
        end else begin
            if (wen) begin
                wr_idx_d = idx_inc(wr_idx_q);
            end
            if (ren) begin
                rd_idx_d = idx_inc(rd_idx_q);
            end
            count_d = count_q + CW'(wen) - CW'(ren);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            count_q  <= '0;
        end else begin
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[wr_idx_q] <= wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Sticky error flags
    // -----------------------------------------------------------------------
`ifdef PROG_FIFO_ERR_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push & full & ~pop) begin
                overflow_d = 1'b1;
            end
            if (pop & empty & ~push) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_prog_fifo.sv
// ---------------------------------------------------------------------------
// tb_prog_fifo -- self-checking bench for prog_fifo (DEPTH 24, WIDTH 16).
// A queue-based reference model tracks contents and sticky error state; every
// cycle the DUT outputs are compared against values derived from the queue.
// ---------------------------------------------------------------------------
module tb_prog_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 24;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             push;
    logic             pop;
    logic             flush;
    logic [WIDTH-1:0] wdata;
    logic [CW-1:0]    af_thresh;
    logic [CW-1:0]    ae_thresh;
    logic [WIDTH-1:0] rdata;
    logic             full;
    logic             empty;
    logic             al_full;
    logic             al_empty;
    logic [CW-1:0]    count;
    logic             ack;
    logic             valid;
    logic             overflow;
    logic             underflow;

    prog_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .wdata     (wdata),
        .af_thresh (af_thresh),
        .ae_thresh (ae_thresh),
        .rdata     (rdata),
        .full      (full),
        .empty     (empty),
        .al_full   (al_full),
        .al_empty  (al_empty),
        .count     (count),
        .ack       (ack),
        .valid     (valid),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] mq [$];
    bit               m_ovf;
    bit               m_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Occupancy-derived outputs and error flags against the model.
    task automatic check_state();
        int n;
        int af;
        int ae;
        bit e_ovf;
        bit e_unf;
        n  = mq.size();
        af = int'(af_thresh);
        ae = int'(ae_thresh);
`ifdef PROG_FIFO_ERR_EN
        e_ovf = m_ovf;
        e_unf = m_unf;
`else
        e_ovf = 1'b0;
        e_unf = 1'b0;
`endif
        check("count",     32'(count),     32'(n));
        check("empty",     32'(empty),     32'(n == 0));
        check("full",      32'(full),      32'(n == DEPTH));
        check("al_full",   32'(al_full),   32'((af != 0) && (n >= af)));
        check("al_empty",  32'(al_empty),  32'(n <= ae));
        check("overflow",  32'(overflow),  32'(e_ovf));
        check("underflow", 32'(underflow), 32'(e_unf));
    endtask

    // One clock of stimulus: drive at the falling edge, check just after,
    // advance the model on the rising edge.
    task automatic cycle(input logic p, input logic q, input logic f, input logic [WIDTH-1:0] d);
        int   n;
        logic e_ack;
        logic e_valid;
        logic through;
        push  = p;
        pop   = q;
        flush = f;
        wdata = d;
        #1;
        n       = mq.size();
        through = !f && p && q && (n == 0);
        e_ack   = !f && p && ((n < DEPTH) || q);
        e_valid = !f && q && ((n > 0) || p);
        check_state();
        check("ack",   32'(ack),   32'(e_ack));
        check("valid", 32'(valid), 32'(e_valid));
        if (through)
            check("rdata_bypass", 32'(rdata), 32'(d));
        else if (n > 0)
            check("rdata_head", 32'(rdata), 32'(mq[0]));
        @(posedge clk);
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (p && !q && n == DEPTH) m_ovf = 1'b1;
            if (q && !p && n == 0)     m_unf = 1'b1;
            if (!through) begin
                if (q && n > 0) mq.delete(0);
                if (e_ack)      mq.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        wdata     = '0;
        af_thresh = CW'(20);
        ae_thresh = CW'(3);
        model_reset();

        // Reset state
        #12;
        check_state();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_state();

        // Wrap: fill, drain half, refill, drain all
        for (int i = 1; i <= 24; i++) cycle(1'b1, 1'b0, 1'b0, 16'(i));
        for (int i = 0; i < 12; i++)  cycle(1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 25; i <= 36; i++) cycle(1'b1, 1'b0, 1'b0, 16'(i));
        for (int i = 0; i < 24; i++)  cycle(1'b0, 1'b1, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);

        // Full: overflow attempt, then push+pop while full, then af disabled
        for (int i = 0; i < 24; i++) cycle(1'b1, 1'b0, 1'b0, 16'($urandom));
        cycle(1'b1, 1'b0, 1'b0, 16'hDEAD);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 1'b0, 16'h1234);
        af_thresh = '0;
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        af_thresh = CW'(20);

        // Flush at count 10 with push and pop asserted
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 1'b1, 16'h5555);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);

        // Bypass through an empty FIFO
        cycle(1'b1, 1'b1, 1'b0, 16'hBEEF);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);

        // Randomized traffic with moving thresholds and occasional flush
        for (int i = 0; i < 600; i++) begin
            logic p;
            logic q;
            logic f;
            if (i % 16 == 0) begin
                af_thresh = CW'($urandom_range(0, DEPTH));
                ae_thresh = CW'($urandom_range(0, DEPTH));
            end
            // Bias towards filling in some phases and draining in others
            if ((i / 100) % 2 == 0) begin
                p = ($urandom_range(0, 3) != 0);
                q = ($urandom_range(0, 3) == 0);
            end else begin
                p = ($urandom_range(0, 3) == 0);
                q = ($urandom_range(0, 3) != 0);
            end
            f = ($urandom_range(0, 40) == 0);
            cycle(p, q, f, 16'($urandom));
        end
        af_thresh = CW'(20);
        ae_thresh = CW'(3);

        // Asynchronous reset mid-operation at count 7
        cycle(1'b1, 1'b1, 1'b1, 16'h0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 16'($urandom));
        check_state();
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_state();
        @(negedge clk);
        check_state();
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 16'hA5A5);
        cycle(1'b0, 1'b1, 1'b0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
